// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch and execute-phase sequencer with PC update logic.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned PC target raises fault and halts until reset.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  PS,
   input  logic [63:0] k,
   input  logic [63:0] reg_in,
   input  logic        next_state,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [63:0] imem_addr,
   output logic        imem_req,
   output logic [31:0] instr,
   output logic        p_state,
   output logic        instr_valid,
   output logic [63:0] PC,
   output logic [63:0] PC4,
   output logic        fault
);

   typedef enum logic [2:0] {FETCH, WAIT, EXEC0, EXEC1, HALT} state_t;

   state_t      state, state_nxt;
   logic [63:0] pc_q, target, pc_new;
   logic [31:0] instr_q;
   logic        fault_q, pc_upd, misalign, fsm_req;

   always_comb begin
      target = pc_q;
      case (PS)
         2'b00: target = pc_q;
         2'b01: target = pc_q + 64'd4;
         2'b10: target = pc_q + (k << 2);
         2'b11: target = reg_in;
         default: target = pc_q;
      endcase
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign = |target[1:0];
   assign pc_new   = target;
`else
   assign misalign = 1'b0;
   assign pc_new   = target & ~64'd3;
`endif

   // A two-phase instruction defers its PC update to EXEC1.
   assign pc_upd = (state == EXEC0 && !next_state) || (state == EXEC1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      fsm_req     = 1'b0;
      instr_valid = 1'b0;
      p_state     = 1'b0;
      case (state)
         FETCH: begin
            fsm_req   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            fsm_req = 1'b1;
            if (imem_valid) state_nxt = EXEC0;
         end
         EXEC0: begin
            instr_valid = 1'b1;
            if (next_state)    state_nxt = EXEC1;
            else if (misalign) state_nxt = HALT;
            else               state_nxt = FETCH;
         end
         EXEC1: begin
            instr_valid = 1'b1;
            p_state     = 1'b1;
            state_nxt   = misalign ? HALT : FETCH;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // State sits in FETCH throughout reset; the request must still stay low.
   assign imem_req = reset & fsm_req;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         if (state == WAIT && imem_valid) instr_q <= imem_rdata;
         if (pc_upd) begin
            pc_q <= pc_new;
            if (misalign) fault_q <= 1'b1;
         end
      end
   end

   assign imem_addr = pc_q;
   assign PC        = pc_q;
   assign PC4       = pc_q + 64'd4;
   assign instr     = instr_q;
   assign fault     = fault_q;

endmodule
